// File: rtl/gray4_tracker.sv
// gray4_tracker
//
// Tracks a 4-bit reflected Gray count arriving asynchronously from a remote
// counter. The Gray value is resynchronised, decoded to binary, and compared
// against the last tracked value to classify each change as a forward step,
// a backward step, or an illegal jump. Forward wraps (15 -> 0) are counted in
// a saturating counter.
//
// Parameters
//   SYNC_STAGES : number of synchronizer flops on gray_in (legal range 2..4)
//   WRAP_W      : width of the forward-wrap counter
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   ce         : tracking enable; the first enabled cycle only primes y
//   clr        : synchronous clear of wraps and err_sticky
//   gray_in    : asynchronous 4-bit Gray count
//   y          : registered binary value of the tracked count
//   step       : one-cycle pulse on a +1 (mod 16) change
//   back       : one-cycle pulse on a -1 (mod 16) change
//   tc         : one-cycle pulse on a forward wrap 15 -> 0 (always with step)
//   err        : one-cycle pulse on any other non-zero change
//   err_sticky : set by err, held until clr or reset
//   wraps      : saturating count of forward wraps
module gray4_tracker #(
    parameter int SYNC_STAGES = 2,
    parameter int WRAP_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              clr,
    input  logic [3:0]        gray_in,
    output logic [3:0]        y,
    output logic              step,
    output logic              back,
    output logic              tc,
    output logic              err,
    output logic              err_sticky,
    output logic [WRAP_W-1:0] wraps
);

    typedef enum logic {
        HOLD  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t                      state;
    logic [SYNC_STAGES-1:0][3:0] gs;
    logic [3:0]                  gs_last;
    logic [3:0]                  bin;
    logic [3:0]                  delta;
    logic                        track_hit;
    logic                        is_step;
    logic                        is_back;
    logic                        is_tc;
    logic                        is_err;

    // Synchronizer chain. It runs every cycle regardless of ce so that the
    // value seen on re-enable is already settled and the prime cycle loads a
    // current count rather than a stale one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gs <= '0;
        end else begin
            gs[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                gs[i] <= gs[i-1];
            end
        end
    end

    assign gs_last = gs[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or
    // above its position.
    always_comb begin
        bin    = '0;
        bin[3] = gs_last[3];
        bin[2] = bin[3] ^ gs_last[2];
        bin[1] = bin[2] ^ gs_last[1];
        bin[0] = bin[1] ^ gs_last[0];
    end

    // Change classification. The delta wraps naturally in 4 bits, so a value
    // of 15 is a single backward step. Only a cycle that is both enabled and
    // already tracking may produce a pulse; the prime cycle never does.
    always_comb begin
        delta     = bin - y;
        track_hit = (state == TRACK) && ce;
        is_step   = track_hit && (delta == 4'd1);
        is_back   = track_hit && (delta == 4'hF);
        is_err    = track_hit && (delta != 4'd0) && (delta != 4'd1) && (delta != 4'hF);
        is_tc     = is_step && (y == 4'hF);
    end

    // Tracking state machine with registered value and pulse outputs.
    // Pulses default low every cycle so each one lasts exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HOLD;
            y     <= '0;
            step  <= 1'b0;
            back  <= 1'b0;
            tc    <= 1'b0;
            err   <= 1'b0;
        end else begin
            step <= is_step;
            back <= is_back;
            tc   <= is_tc;
            err  <= is_err;
            case (state)
                HOLD: begin
                    if (ce) begin
                        y     <= bin;
                        state <= TRACK;
                    end
                end
                TRACK: begin
                    if (ce) begin
                        y <= bin;
                    end else begin
                        state <= HOLD;
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end

    // Wrap counter and sticky error. clr wins over a coincident tc or err
    // so software can always get back to a clean slate in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wraps      <= '0;
            err_sticky <= 1'b0;
        end else if (clr) begin
            wraps      <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (is_tc && (wraps != {WRAP_W{1'b1}})) begin
                wraps <= wraps + 1'b1;
            end
            if (is_err) begin
                err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gray4_tracker.sv
// tb_gray4_tracker
//
// Directed bench for gray4_tracker with the default parameters
// (SYNC_STAGES = 2, WRAP_W = 8). Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point, away from the edge.
module tb_gray4_tracker;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic       clr;
    logic [3:0] gray_in;
    logic [3:0] y;
    logic       step;
    logic       back;
    logic       tc;
    logic       err;
    logic       err_sticky;
    logic [7:0] wraps;

    int checks;
    int errors;
    int stepCnt;
    int backCnt;
    int tcCnt;
    int errCnt;
    int tcWithStep;

    gray4_tracker #(
        .SYNC_STAGES(2),
        .WRAP_W     (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .clr       (clr),
        .gray_in   (gray_in),
        .y         (y),
        .step      (step),
        .back      (back),
        .tc        (tc),
        .err       (err),
        .err_sticky(err_sticky),
        .wraps     (wraps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a stuck run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [3:0] toGray(input int k);
        logic [3:0] b;
        b = 4'(k);
        return b ^ (b >> 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearCounts();
        stepCnt    = 0;
        backCnt    = 0;
        tcCnt      = 0;
        errCnt     = 0;
        tcWithStep = 0;
    endtask

    // Advance one clock and sample 1 unit later, tallying every pulse seen.
    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            stepCnt    += int'(step);
            backCnt    += int'(back);
            tcCnt      += int'(tc);
            errCnt     += int'(err);
            tcWithStep += int'(tc && step);
        end
    endtask

    // Park at a Gray value with ce low long enough for the synchronizer to
    // settle, then re-enable so the prime cycle loads it quietly.
    task automatic reprime(input logic [3:0] g);
        ce      = 1'b0;
        gray_in = g;
        applyStimulus(3);
        ce = 1'b1;
        applyStimulus(3);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        ce      = 1'b0;
        clr     = 1'b0;
        gray_in = 4'b0110;
        clearCounts();

        // Reset state
        applyStimulus(3);
        checkOutput("reset_y", y, 0);
        checkOutput("reset_pulses", {step, back, tc, err}, 0);
        checkOutput("reset_sticky", err_sticky, 0);
        checkOutput("reset_wraps", wraps, 0);

        // Held Gray 0110 (binary 4): prime loads 4 with no pulses
        rst_n = 1'b1;
        applyStimulus(3);
        clearCounts();
        ce = 1'b1;
        applyStimulus(6);
        checkOutput("hold_y", y, 4);
        checkOutput("hold_pulses", stepCnt + backCnt + tcCnt + errCnt, 0);

        // Forward walk through all 16 codes ending in a wrap
        reprime(4'b0000);
        checkOutput("prime0_y", y, 0);
        checkOutput("prime0_err", errCnt, 0);
        clearCounts();
        for (int k = 1; k <= 16; k++) begin
            gray_in = toGray(k);
            applyStimulus(4);
            checkOutput($sformatf("walk_y_%0d", k), y, k % 16);
        end
        checkOutput("walk_steps", stepCnt, 16);
        checkOutput("walk_tc", tcCnt, 1);
        checkOutput("walk_tc_with_step", tcWithStep, 1);
        checkOutput("walk_back_err", backCnt + errCnt, 0);
        checkOutput("walk_wraps", wraps, 1);

        // Backward step 0 -> 15, with exact latency: y moves after 3 edges
        clearCounts();
        gray_in = 4'b1000;
        applyStimulus(2);
        checkOutput("back_latency_y", y, 0);
        checkOutput("back_latency_pulse", back, 0);
        applyStimulus(1);
        checkOutput("back_y", y, 15);
        checkOutput("back_pulse", back, 1);
        applyStimulus(2);
        checkOutput("back_count", backCnt, 1);
        checkOutput("back_step_tc", stepCnt + tcCnt, 0);
        checkOutput("back_wraps", wraps, 1);

        // Illegal jump 0 -> 2, then clear
        reprime(4'b0000);
        clearCounts();
        gray_in = 4'b0011;
        applyStimulus(4);
        checkOutput("err_y", y, 2);
        checkOutput("err_count", errCnt, 1);
        checkOutput("err_step", stepCnt, 0);
        checkOutput("err_sticky_set", err_sticky, 1);
        clr = 1'b1;
        applyStimulus(1);
        clr = 1'b0;
        checkOutput("clr_sticky", err_sticky, 0);
        checkOutput("clr_wraps", wraps, 0);
        checkOutput("clr_keeps_y", y, 2);

        // Disabled while input moves 0 -> Gray 0101 (binary 6)
        reprime(4'b0000);
        clearCounts();
        ce      = 1'b0;
        gray_in = 4'b0101;
        applyStimulus(4);
        checkOutput("ce_off_y", y, 0);
        ce = 1'b1;
        applyStimulus(3);
        checkOutput("reenable_y", y, 6);
        checkOutput("reenable_pulses", stepCnt + backCnt + tcCnt + errCnt, 0);

        // Drive wraps to saturation with one step per cycle
        reprime(4'b0000);
        clearCounts();
        for (int w = 0; w < 255; w++) begin
            for (int k = 1; k <= 16; k++) begin
                gray_in = toGray(k);
                applyStimulus(1);
            end
        end
        applyStimulus(3);
        checkOutput("sat_tc_count", tcCnt, 255);
        checkOutput("sat_err", errCnt, 0);
        checkOutput("sat_wraps", wraps, 255);
        clearCounts();
        for (int k = 1; k <= 16; k++) begin
            gray_in = toGray(k);
            applyStimulus(1);
        end
        applyStimulus(3);
        checkOutput("sat_extra_tc", tcCnt, 1);
        checkOutput("sat_hold_wraps", wraps, 255);

        // Asynchronous reset mid-walk, between clock edges
        for (int k = 1; k <= 8; k++) begin
            gray_in = toGray(k);
            applyStimulus(1);
        end
        checkOutput("pre_reset_y", y, 6);
        checkOutput("pre_reset_step", step, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_y", y, 0);
        checkOutput("async_pulses", {step, back, tc, err}, 0);
        checkOutput("async_wraps", wraps, 0);
        checkOutput("async_sticky", err_sticky, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
